// File: rtl/sha_ctrl_pkg.sv
// Shared constants for the SHA-256 round controller: round constants, rotate/shift
// amounts, the FSM state type and the standard initial hash value.
package sha_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_UPDATE,
      S_FINAL
   } state_t;

   // Sigma1 (T1 path) and Sigma0 (T2 path) rotate amounts, also driven to the stage
   localparam int unsigned BS1_R0 = 6;
   localparam int unsigned BS1_R1 = 11;
   localparam int unsigned BS1_R2 = 25;
   localparam int unsigned BS0_R0 = 2;
   localparam int unsigned BS0_R1 = 13;
   localparam int unsigned BS0_R2 = 22;

   // message-schedule sigma0/sigma1: two rotates and one logical shift each
   localparam int unsigned SS0_R0 = 7;
   localparam int unsigned SS0_R1 = 18;
   localparam int unsigned SS0_SH = 3;
   localparam int unsigned SS1_R0 = 17;
   localparam int unsigned SS1_R1 = 19;
   localparam int unsigned SS1_SH = 10;

   localparam logic [255:0] IV =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr32(x, SS0_R0) ^ rotr32(x, SS0_R1) ^ (x >> SS0_SH);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr32(x, SS1_R0) ^ rotr32(x, SS1_R1) ^ (x >> SS1_SH);
   endfunction

endpackage

// File: rtl/sha_msg_sched.sv
// SHA-256 message expansion: 16-word shift window producing W[t] for t >= 16.
// Only instantiated when SHA_ROUND_CTRL_MSG_SCHED_EN is defined.
module sha_msg_sched
   import sha_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_shift,
   input  logic [DATA_W-1:0] i_word,
   output logic [DATA_W-1:0] o_next
);

   // r_win[0] is W[t-1], r_win[15] is W[t-16]
   logic [DATA_W-1:0] r_win [16];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 16; i++) r_win[i] <= '0;
      end else if (i_shift) begin
         r_win[0] <= i_word;
         for (int unsigned i = 1; i < 16; i++) r_win[i] <= r_win[i-1];
      end
   end

   assign o_next = small_sigma1(r_win[1]) + r_win[6] + small_sigma0(r_win[14]) + r_win[15];

endmodule

// File: rtl/sha_round_ctrl.sv
// SHA-256 compression sequencer around an external T_Stage (T1/T2) datapath.
// Define SHA_ROUND_CTRL_MSG_SCHED_EN to expand W[16..63] internally.
module sha_round_ctrl
   import sha_ctrl_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int STAGE_LAT = 2,
   parameter int ROUNDS    = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [8*DATA_W-1:0]   h_in,
   input  logic [DATA_W-1:0]     w_data,
   input  logic                  w_valid,
   output logic                  w_ready,
   output logic                  busy,
   output logic                  done,
   output logic [8*DATA_W-1:0]   digest,
   output logic [5:0]            round,
   output logic                  stage_run,
   output logic [DATA_W-1:0]     stage_in0,
   output logic [DATA_W-1:0]     stage_in1,
   output logic [DATA_W-1:0]     stage_in2,
   output logic [DATA_W-1:0]     stage_in3,
   output logic [DATA_W-1:0]     stage_in4,
   output logic [DATA_W-1:0]     stage_in5,
   output logic [DATA_W-1:0]     stage_in6,
   output logic [DATA_W-1:0]     stage_in7,
   output logic [DATA_W-1:0]     stage_in8,
   output logic [31:0]           stage_c0,
   output logic [31:0]           stage_c1,
   output logic [31:0]           stage_c2,
   output logic [31:0]           stage_c3,
   output logic [31:0]           stage_c4,
   output logic [31:0]           stage_c5,
   input  logic [DATA_W-1:0]     stage_t1,
   input  logic [DATA_W-1:0]     stage_t2
);

   state_t              r_state, w_next;
   logic [5:0]          r_round;
   logic [3:0]          r_cnt;
   logic                r_busy, r_done;
   logic [DATA_W-1:0]   r_var [8];   // a..h
   logic [DATA_W-1:0]   r_h   [8];   // H0..H7
   logic [DATA_W-1:0]   r_w, r_k, r_t1, r_t2;
   logic [8*DATA_W-1:0] r_digest;

   logic                w_start_ok, w_hs_phase, w_fetch, w_rdy, w_run;
   logic [DATA_W-1:0]   w_word;

   // busy gates start so a start in the done cycle is not taken
   assign w_start_ok = (r_state == S_IDLE) && start && !r_busy;

`ifdef SHA_ROUND_CTRL_MSG_SCHED_EN
   logic [DATA_W-1:0] w_sched;
   assign w_hs_phase = (r_round < 6'd16);
   assign w_word     = w_hs_phase ? w_data : w_sched;
   sha_msg_sched #(.DATA_W(DATA_W)) u_msg_sched (
      .clk     (clk),
      .rst     (rst),
      .i_shift (w_fetch),
      .i_word  (w_word),
      .o_next  (w_sched)
   );
`else
   assign w_hs_phase = 1'b1;
   assign w_word     = w_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_rdy   = 1'b0;
      w_fetch = 1'b0;
      w_run   = 1'b0;
      case (r_state)
         S_IDLE:   if (w_start_ok) w_next = S_FETCH;
         S_FETCH: begin
            w_rdy   = w_hs_phase;
            w_fetch = w_hs_phase ? w_valid : 1'b1;
            if (w_fetch) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            w_run  = 1'b1;
            w_next = S_WAIT;
         end
         S_WAIT:   if (r_cnt == 4'd1) w_next = S_UPDATE;
         S_UPDATE: w_next = (r_round == 6'(ROUNDS - 1)) ? S_FINAL : S_FETCH;
         S_FINAL:  w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_round  <= '0;
         r_cnt    <= '0;
         r_w      <= '0;
         r_k      <= '0;
         r_t1     <= '0;
         r_t2     <= '0;
         r_digest <= '0;
         for (int unsigned i = 0; i < 8; i++) begin
            r_var[i] <= '0;
            r_h[i]   <= '0;
         end
      end else begin
         r_done <= 1'b0;
         if (r_done) r_busy <= 1'b0;
         case (r_state)
            S_IDLE: if (w_start_ok) begin
               r_busy  <= 1'b1;
               r_round <= '0;
               for (int unsigned i = 0; i < 8; i++) begin
                  r_h[i]   <= h_in[(7-i)*DATA_W +: DATA_W];
                  r_var[i] <= h_in[(7-i)*DATA_W +: DATA_W];
               end
            end
            // K is registered alongside W so stage_in7 reads 0 out of reset
            S_FETCH: if (w_fetch) begin
               r_w <= w_word;
               r_k <= K[r_round];
            end
            S_ISSUE: r_cnt <= 4'(STAGE_LAT);
            S_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_t1 <= stage_t1;
                  r_t2 <= stage_t2;
               end
            end
            S_UPDATE: begin
               r_var[7] <= r_var[6];
               r_var[6] <= r_var[5];
               r_var[5] <= r_var[4];
               r_var[4] <= r_var[3] + r_t1;
               r_var[3] <= r_var[2];
               r_var[2] <= r_var[1];
               r_var[1] <= r_var[0];
               r_var[0] <= r_t1 + r_t2;
               if (r_round != 6'(ROUNDS - 1)) r_round <= r_round + 6'd1;
            end
            S_FINAL: begin
               for (int unsigned i = 0; i < 8; i++)
                  r_digest[(7-i)*DATA_W +: DATA_W] <= r_h[i] + r_var[i];
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign w_ready   = w_rdy;
   assign stage_run = w_run;
   assign busy      = r_busy;
   assign done      = r_done;
   assign digest    = r_digest;
   assign round     = r_round;

   // d is not a stage input: e <= d + T1 happens here
   assign stage_in0 = r_var[0];
   assign stage_in1 = r_var[1];
   assign stage_in2 = r_var[2];
   assign stage_in3 = r_var[4];
   assign stage_in4 = r_var[5];
   assign stage_in5 = r_var[6];
   assign stage_in6 = r_var[7];
   assign stage_in7 = r_k;
   assign stage_in8 = r_w;

   assign stage_c0 = 32'(BS1_R0);
   assign stage_c1 = 32'(BS1_R1);
   assign stage_c2 = 32'(BS1_R2);
   assign stage_c3 = 32'(BS0_R0);
   assign stage_c4 = 32'(BS0_R1);
   assign stage_c5 = 32'(BS0_R2);

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Scoreboard bench for sha_round_ctrl with a behavioural SHA-256 reference and a
// pipelined T_Stage model of STAGE_LAT cycles.
module tb_sha_round_ctrl;
   import sha_ctrl_pkg::*;

   localparam int LAT = 2;
   localparam int NR  = 64;
`ifdef SHA_ROUND_CTRL_MSG_SCHED_EN
   localparam int EXP_HS = 16;
`else
   localparam int EXP_HS = 64;
`endif
   localparam logic [255:0] ABC_DIG =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] TWO_DIG =
      256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   logic          clk = 1'b0;
   logic          rst, start, w_valid, w_ready, busy, done, stage_run;
   logic [255:0]  h_in, digest;
   logic [31:0]   w_data, stage_t1, stage_t2;
   logic [5:0]    round;
   logic [31:0]   stage_in0, stage_in1, stage_in2, stage_in3, stage_in4;
   logic [31:0]   stage_in5, stage_in6, stage_in7, stage_in8;
   logic [31:0]   stage_c0, stage_c1, stage_c2, stage_c3, stage_c4, stage_c5;

   sha_round_ctrl #(.DATA_W(32), .STAGE_LAT(LAT), .ROUNDS(NR)) dut (
      .clk(clk), .rst(rst), .start(start), .h_in(h_in),
      .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
      .busy(busy), .done(done), .digest(digest), .round(round),
      .stage_run(stage_run),
      .stage_in0(stage_in0), .stage_in1(stage_in1), .stage_in2(stage_in2),
      .stage_in3(stage_in3), .stage_in4(stage_in4), .stage_in5(stage_in5),
      .stage_in6(stage_in6), .stage_in7(stage_in7), .stage_in8(stage_in8),
      .stage_c0(stage_c0), .stage_c1(stage_c1), .stage_c2(stage_c2),
      .stage_c3(stage_c3), .stage_c4(stage_c4), .stage_c5(stage_c5),
      .stage_t1(stage_t1), .stage_t2(stage_t2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference arithmetic ----------------
   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] bs0(input logic [31:0] x);
      return rr(x, 2) ^ rr(x, 13) ^ rr(x, 22);
   endfunction
   function automatic logic [31:0] bs1(input logic [31:0] x);
      return rr(x, 6) ^ rr(x, 11) ^ rr(x, 25);
   endfunction
   function automatic logic [31:0] ss0(input logic [31:0] x);
      return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] ss1(input logic [31:0] x);
      return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
   endfunction

   logic [31:0] blkw [64];

   task automatic set_block(input logic [511:0] m);
      for (int i = 0; i < 16; i++) blkw[i] = m[511-32*i -: 32];
      for (int t = 16; t < 64; t++)
         blkw[t] = ss1(blkw[t-2]) + blkw[t-7] + ss0(blkw[t-15]) + blkw[t-16];
   endtask

   function automatic logic [255:0] ref_compress(input logic [255:0] hin);
      logic [31:0]  v [8];
      logic [31:0]  hh [8];
      logic [31:0]  t1, t2;
      logic [255:0] r;
      for (int i = 0; i < 8; i++) begin
         hh[i] = hin[255-32*i -: 32];
         v[i]  = hh[i];
      end
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + bs1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + blkw[t];
         t2 = bs0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
         v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hh[i] + v[i];
      return r;
   endfunction

   // ---------------- T_Stage model ----------------
   logic [31:0]  p1 [16];
   logic [31:0]  p2 [16];
   logic [287:0] sin_all, snap;
   int           hold = 0;
   int           stab_err = 0;

   assign sin_all = {stage_in0, stage_in1, stage_in2, stage_in3, stage_in4,
                     stage_in5, stage_in6, stage_in7, stage_in8};
   assign stage_t1 = p1[LAT-1];
   assign stage_t2 = p2[LAT-1];

   always @(posedge clk) begin
      p1[0] <= stage_run ? (stage_in6 + bs1(stage_in3) +
                            ((stage_in3 & stage_in4) ^ (~stage_in3 & stage_in5)) +
                            stage_in7 + stage_in8) : $urandom;
      p2[0] <= stage_run ? (bs0(stage_in0) + ((stage_in0 & stage_in1) ^
                            (stage_in0 & stage_in2) ^ (stage_in1 & stage_in2))) : $urandom;
      for (int i = 1; i < 16; i++) begin
         p1[i] <= p1[i-1];
         p2[i] <= p2[i-1];
      end
      if (rst)              hold <= 0;
      else if (stage_run) begin
         snap <= sin_all;
         hold <= LAT + 1;
      end else if (hold > 0) hold <= hold - 1;
   end

   always @(negedge clk)
      if (hold > 0 && sin_all !== snap) stab_err++;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [255:0] dig;
      int           lat;
      int           t0;
   } exp_t;
   exp_t sb [$];
   exp_t e;

   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got a done pulse, required none outstanding");
         end else begin
            e = sb.pop_front();
            check("digest", digest, e.dig);
            if (e.lat > 0) check("latency", 256'(cyc - e.t0 + 1), 256'(e.lat));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_block(input logic [255:0] hin, input logic [255:0] exp_d, input int lat_exp,
                            input int max_stall, input bit spam, input int abort_cyc);
      int   g, k, stall, spams;
      bit   hs;
      exp_t ent;
      g = 0;
      while (busy && g < 5000) begin
         @(negedge clk);
         g++;
      end
      if (busy) begin
         check("idle_timeout", 256'(busy), 256'(0));
         return;
      end
      h_in  = hin;
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      ent.dig = exp_d;
      ent.lat = lat_exp;
      ent.t0  = cyc;
      sb.push_back(ent);
      k = 0;
      spams = 0;
      stall = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
      g = 0;
      while (!done && g < 20000) begin
         if (abort_cyc >= 0 && g == abort_cyc) begin
            rst     = 1'b1;
            w_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            void'(sb.pop_back());
            check("abort_busy", 256'(busy), 256'(0));
            check("abort_digest", digest, 256'(0));
            check("abort_round", 256'(round), 256'(0));
            check("abort_done", 256'(done), 256'(0));
            return;
         end
         if (stall > 0) begin
            w_valid = 1'b0;
            w_data  = $urandom;
            stall--;
         end else begin
            w_valid = 1'b1;
            w_data  = (k < 64) ? blkw[k] : $urandom;
         end
         start = spam && spams < 10 && (g % 23 == 7);
         if (start) spams++;
         hs = w_valid && w_ready;
         @(negedge clk);
         g++;
         if (hs) begin
            k++;
            stall = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
         end
      end
      w_valid = 1'b0;
      start   = 1'b0;
      if (!done) begin
         check("done_timeout", 256'(done), 256'(1));
         return;
      end
      check("words_consumed", 256'(k), 256'(EXP_HS));
      check("busy_at_done", 256'(busy), 256'(1));
      start = spam;   // start during the done cycle must not launch a block
      @(negedge clk);
      start = 1'b0;
      check("busy_after_done", 256'(busy), 256'(0));
      @(negedge clk);
      check("busy_stays_low", 256'(busy), 256'(0));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   localparam logic [511:0] ABC_MSG = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] TWO_M1  = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] TWO_M2  = {480'h0, 32'h000001c0};

   initial begin
      logic [255:0] mid, hr;
      logic [511:0] m;
      rst = 1'b1; start = 1'b0; w_valid = 1'b1; w_data = '0; h_in = IV;
      repeat (3) @(negedge clk);
      check("rst_busy", 256'(busy), 256'(0));
      check("rst_done", 256'(done), 256'(0));
      check("rst_w_ready", 256'(w_ready), 256'(0));
      check("rst_stage_run", 256'(stage_run), 256'(0));
      check("rst_round", 256'(round), 256'(0));
      check("rst_digest", digest, 256'(0));
      check("rst_stage_in_hi", 256'(sin_all[287:256]), 256'(0));
      check("rst_stage_in_lo", sin_all[255:0], 256'(0));
      check("stage_consts", 256'({stage_c0, stage_c1, stage_c2, stage_c3, stage_c4, stage_c5}),
            256'({32'd6, 32'd11, 32'd25, 32'd2, 32'd13, 32'd22}));
      rst = 1'b0;
      w_valid = 1'b0;
      @(negedge clk);

      set_block(ABC_MSG);
      run_block(IV, ABC_DIG, 2 + NR * (3 + LAT), 0, 1'b0, -1);
      run_block(IV, ABC_DIG, 0, 5, 1'b0, -1);
      run_block(IV, ABC_DIG, 0, 2, 1'b1, -1);
      run_block(IV, ABC_DIG, 0, 0, 1'b0, 30 * (3 + LAT) + 1);
      run_block(IV, ABC_DIG, 2 + NR * (3 + LAT), 0, 1'b0, -1);

      set_block(TWO_M1);
      mid = ref_compress(IV);
      run_block(IV, mid, 0, 3, 1'b0, -1);
      set_block(TWO_M2);
      run_block(mid, TWO_DIG, 0, 3, 1'b0, -1);

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 16; i++) m[511-32*i -: 32] = $urandom;
         for (int i = 0; i < 8; i++)  hr[255-32*i -: 32] = $urandom;
         set_block(m);
         run_block(hr, ref_compress(hr), (r == 0) ? 2 + NR * (3 + LAT) : 0, r, r == 2, -1);
      end

      repeat (3) @(negedge clk);
      check("stage_in_stable", 256'(stab_err), 256'(0));
      check("scoreboard_drained", 256'(sb.size()), 256'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
